// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a linear RAM address range, issues reads at up to
// one per cycle, absorbs the RAM's 1-cycle read latency and streams the
// returned words out through a small credit-controlled FIFO.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_WIDTH-1:0]  beat_rem_q, beat_rem_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0]      rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic                  start_acc_s;
  logic                  zero_len_s;
  logic                  issue_s;
  logic                  beat_s;
  logic                  last_beat_s;
  logic                  valid_s;
  logic [CNT_W-1:0]      credit_used_s;

  // Decode of command acceptance, read issue and stream beats for this cycle.
  always_comb begin
    valid_s       = (fifo_cnt_q != '0);
    start_acc_s   = start && (state_q == ST_IDLE);
    zero_len_s    = (length == '0);
    credit_used_s = fifo_cnt_q + CNT_W'(inflight_q);
    issue_s       = (state_q == ST_RUN) && (issue_rem_q != '0) && (credit_used_s < DEPTH_C);
    beat_s        = valid_s && m_ready;
    last_beat_s   = beat_s && (beat_rem_q == LEN_WIDTH'(1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM next-state logic; done pulses after a zero-length command or the final beat.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc_s) begin
          if (zero_len_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && (issue_rem_q == LEN_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (last_beat_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // FSM outputs and RAM port drive; the RAM address is the read pointer itself.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    mem_addr = rd_ptr_q;
    mem_wr   = 1'b0;
    mem_din  = '0;
    m_valid  = valid_s;
    m_data   = fifo_mem_q[rd_idx_q];
    m_last   = valid_s && (beat_rem_q == LEN_WIDTH'(1));
  end

  // Datapath next state: command latch, issue/beat counters and FIFO bookkeeping.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    issue_rem_d = issue_rem_q;
    beat_rem_d  = beat_rem_q;
    inflight_d  = issue_s;
    fifo_mem_d  = fifo_mem_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(inflight_q) - CNT_W'(beat_s);

    // A zero-length command leaves the read pointer (and mem_addr) untouched.
    if (start_acc_s && !zero_len_s) begin
      rd_ptr_d    = base_addr;
      issue_rem_d = length;
      beat_rem_d  = length;
    end else begin
      if (issue_s) begin
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        issue_rem_d = issue_rem_q - LEN_WIDTH'(1);
      end else begin
        rd_ptr_d    = rd_ptr_q;
        issue_rem_d = issue_rem_q;
      end
      if (beat_s) begin
        beat_rem_d = beat_rem_q - LEN_WIDTH'(1);
      end else begin
        beat_rem_d = beat_rem_q;
      end
    end

    // The word requested last cycle is on mem_dout now; credit guarantees room.
    if (inflight_q) begin
      fifo_mem_d[wr_idx_q] = mem_dout;
      wr_idx_d             = wr_idx_q + PTR_W'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (beat_s) begin
      rd_idx_d = rd_idx_q + PTR_W'(1);
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // Datapath registers; reset aborts any burst and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      issue_rem_q <= issue_rem_d;
      beat_rem_q  <= beat_rem_d;
      inflight_q  <= inflight_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a behavioural RAM plus a queue
// of expected words per burst, with random back-pressure on m_ready.
module tb_bram_stream_reader;

  localparam int DW    = 72;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int FD    = 4;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] ram [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  bram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Behavioural RAM read port: data appears one edge after the address.
  always @(posedge clk) mem_dout <= ram[mem_addr];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst: start, consume all beats with the given ready behaviour, check done.
  task automatic run_burst(input int base, input int len, input int ready_pct,
                           input int stall, input bit poke, input string tag);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            prev_stall;
    int            beats, dones, first_beat, last_beat, cyc;
    beats = 0; dones = 0; first_beat = -1; last_beat = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    for (int k = 0; k < len; k++) exp_q.push_back(ram[(base + k) % DEPTH]);

    @(negedge clk);
    base_addr = AW'(base); length = LW'(len); start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " busy_after_start"}, DW'(busy), DW'(1));
    check({tag, " valid_after_start"}, DW'(m_valid), DW'(0));

    while (beats < len && cyc < 40 * len + 100) begin
      if (stall > 0 && cyc == stall + 1) begin
        check({tag, " addr_after_stall"}, DW'(mem_addr), DW'((base + FD) % DEPTH));
        check({tag, " data_during_stall"}, m_data, exp_q[0]);
      end
      m_ready = (cyc > stall) && ($urandom_range(99) < ready_pct);
      if (poke && cyc == 5) begin
        start = 1'b1; base_addr = AW'(base + 100); length = LW'(3);
      end else begin
        start = 1'b0;
      end
      if (done) dones++;
      if (prev_stall) begin
        check({tag, " hold_valid"}, DW'(m_valid), DW'(1));
        check({tag, " hold_data"}, m_data, prev_data);
        check({tag, " hold_last"}, DW'(m_last), DW'(prev_last));
      end
      if (m_valid && m_ready) begin
        check({tag, " beat_data"}, m_data, exp_q[0]);
        check({tag, " beat_last"}, DW'(m_last), DW'(exp_q.size() == 1));
        void'(exp_q.pop_front());
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    check({tag, " beat_count"}, DW'(beats), DW'(len));
    check({tag, " done_pulse"}, DW'(done), DW'(1));
    check({tag, " busy_cleared"}, DW'(busy), DW'(0));
    check({tag, " valid_after_last"}, DW'(m_valid), DW'(0));
    check({tag, " early_done"}, DW'(dones), DW'(0));
    check({tag, " reads_issued"}, DW'(mem_addr), DW'((base + len) % DEPTH));
    if (ready_pct == 100 && stall == 0) begin
      check({tag, " first_valid_cycle"}, DW'(first_beat), DW'(3));
      check({tag, " consecutive_beats"}, DW'(last_beat - first_beat), DW'(len - 1));
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, DW'(done), DW'(0));
    check({tag, " no_extra_beat"}, DW'(m_valid), DW'(0));
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    int            b, cyc, rbase, rlen;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst busy", DW'(busy), DW'(0));
    check("rst done", DW'(done), DW'(0));
    check("rst valid", DW'(m_valid), DW'(0));
    check("rst last", DW'(m_last), DW'(0));
    check("rst addr", DW'(mem_addr), DW'(0));
    check("rst mem_wr", DW'(mem_wr), DW'(0));
    check("rst mem_din", mem_din, DW'(0));
    rst = 1'b0;

    // Directed bursts from the plan.
    run_burst(16, 4, 100, 0, 1'b0, "basic");
    run_burst(1022, 4, 100, 0, 1'b0, "wrap");
    run_burst(0, 8, 100, 10, 1'b0, "stall");
    run_burst(0, 1024, 50, 0, 1'b1, "full_random");

    // Zero-length command: immediate done, no reads, no beats.
    @(negedge clk);
    prev_addr = mem_addr;
    base_addr = AW'(12'h155); length = '0; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0 done", DW'(done), DW'(1));
    check("len0 valid", DW'(m_valid), DW'(0));
    check("len0 addr", DW'(mem_addr), DW'(prev_addr));
    @(negedge clk);
    check("len0 done_clear", DW'(done), DW'(0));
    check("len0 busy", DW'(busy), DW'(0));
    check("len0 valid_later", DW'(m_valid), DW'(0));

    // Reset in the middle of a 16-word burst after three beats.
    base_addr = '0; length = LW'(16); start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0; cyc = 0;
    while (b < 3 && cyc < 50) begin
      if (m_valid && m_ready) b++;
      @(negedge clk);
      cyc++;
    end
    check("midrst beats_before", DW'(b), DW'(3));
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", DW'(busy), DW'(0));
    check("midrst valid", DW'(m_valid), DW'(0));
    check("midrst done", DW'(done), DW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("midrst no_done", DW'(done), DW'(0));
    check("midrst still_idle", DW'(busy), DW'(0));
    run_burst(32, 2, 100, 0, 1'b0, "after_reset");

    // Random RAM contents, random ranges and back-pressure.
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'({$urandom, $urandom, $urandom});
    for (int t = 0; t < 4; t++) begin
      rbase = int'($urandom_range(DEPTH - 1));
      rlen  = int'($urandom_range(40, 1));
      run_burst(rbase, rlen, 70, 0, 1'b0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
